// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, instruction format enum and the queued decode record.
// Widths are sized for XLEN_MAX and truncated to the instance XLEN where they are used.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_INV = 3'd7
  } format_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    format_e             format;
    logic                illegal;
  } decoded_t;

  // Base and alternate encodings are the only funct7 values R-type ops use.
  function automatic logic funct7_known(input logic [6:0] f7);
    return (f7 == 7'b0000000) || (f7 == 7'b0100000);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-consumer handshake bundle; slave is the decode stage side.
// Both sides use valid/ready; flush travels with the fetch side.
interface decode_stage_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_format;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_format, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_format, out_illegal
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV field/immediate extraction, zero latency, no handshake.
// DECODE_ILLEGAL_CHECK_EN enables the illegal flag (invalid format or unknown R-type funct7).
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decoded_t        dec_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]          opcode;
  logic [XLEN_MAX-1:0] imm_i;
  logic [XLEN_MAX-1:0] imm_s;
  logic [XLEN_MAX-1:0] imm_b;
  logic [XLEN_MAX-1:0] imm_u;
  logic [XLEN_MAX-1:0] imm_j;

  assign opcode = instr_i[6:0];
  assign imm_i  = {{52{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
  assign imm_j  = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec_o        = '0;
    dec_o.format = FMT_INV;
    dec_o.pc     = XLEN_MAX'(pc_i);
    if (instr_i[1:0] == 2'b11) begin
      case (opcode)
        OP_REG, OP_REG32: begin
          // W-form register ops do not exist on a 32-bit datapath
          if (opcode == OP_REG || RV64) begin
            dec_o.format = FMT_R;
            dec_o.rd     = instr_i[11:7];
            dec_o.rs1    = instr_i[19:15];
            dec_o.rs2    = instr_i[24:20];
            dec_o.funct3 = instr_i[14:12];
            dec_o.funct7 = instr_i[31:25];
          end
        end
        OP_IMM, OP_LOAD, OP_JALR: begin
          dec_o.format = FMT_I;
          dec_o.rd     = instr_i[11:7];
          dec_o.rs1    = instr_i[19:15];
          dec_o.funct3 = instr_i[14:12];
          dec_o.imm    = imm_i;
        end
        OP_IMM32: begin
          if (RV64) begin
            dec_o.format = FMT_I;
            dec_o.rd     = instr_i[11:7];
            dec_o.rs1    = instr_i[19:15];
            dec_o.funct3 = instr_i[14:12];
            dec_o.funct7 = instr_i[31:25];
            dec_o.imm    = imm_i;
          end
        end
        OP_STORE: begin
          dec_o.format = FMT_S;
          dec_o.rs1    = instr_i[19:15];
          dec_o.rs2    = instr_i[24:20];
          dec_o.funct3 = instr_i[14:12];
          dec_o.imm    = imm_s;
        end
        OP_BRANCH: begin
          dec_o.format = FMT_B;
          dec_o.rs1    = instr_i[19:15];
          dec_o.rs2    = instr_i[24:20];
          dec_o.funct3 = instr_i[14:12];
          dec_o.imm    = imm_b;
        end
        OP_LUI, OP_AUIPC: begin
          dec_o.format = FMT_U;
          dec_o.rd     = instr_i[11:7];
          dec_o.imm    = imm_u;
        end
        OP_JAL: begin
          dec_o.format = FMT_J;
          dec_o.rd     = instr_i[11:7];
          dec_o.imm    = imm_j;
        end
        default: dec_o.format = FMT_INV;
      endcase
    end
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec_o.illegal = (dec_o.format == FMT_INV) ||
                    ((dec_o.format == FMT_R) && !funct7_known(dec_o.funct7));
`else
    dec_o.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes on accept into a DEPTH-entry queue, head valid one cycle later.
// in_ready = !full with no pop-through while full; flush empties the queue. Illegal flag needs DECODE_ILLEGAL_CHECK_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_t         dec;
  decoded_t         head;
  decoded_t         mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .instr_i (bus.in_instr),
    .pc_i    (bus.in_pc),
    .dec_o   (dec)
  );

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // An accept coinciding with flush is dropped rather than queued behind the flush
  assign push  = bus.in_valid && !full && !bus.flush;
  assign pop   = !empty && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every output is masked while the queue is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign bus.in_ready    = !full;
  assign bus.out_valid   = !empty;
  assign bus.out_pc      = head.pc[XLEN-1:0];
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_funct7  = head.funct7;
  assign bus.out_imm     = head.imm[XLEN-1:0];
  assign bus.out_format  = head.format;
  assign bus.out_illegal = head.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL be parametrised as follows, one per line: name, default, meaning.
- XLEN, 64, datapath width; legal values 32 or 64.
- DEPTH, 2, output queue entries; power of two, at least 2.

REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- flush, in, 1, discard all queued entries.
- in_valid, in, 1, fetch offers an instruction.
- in_ready, out, 1, block accepts this cycle.
- in_instr, in, 32, instruction word.
- in_pc, in, XLEN, instruction address.
- out_valid, out, 1, queue head is valid.
- out_ready, in, 1, consumer takes the head.
- out_pc, out, XLEN, head pc.
- out_rd / out_rs1 / out_rs2, out, 5 each, register fields.
- out_funct3, out, 3, function code.
- out_funct7, out, 7, function extension.
- out_imm, out, XLEN, sign-extended immediate.
- out_format, out, 3, R=0 I=1 S=2 B=3 U=4 J=5 invalid=7.
- out_illegal, out, 1, head instruction is illegal.

Function
REQ-003 Decode SHALL be combinational on in_instr, with the result written into the queue on accept (in_valid && in_ready); out_valid SHALL rise on the cycle after accept (1-cycle latency).
REQ-004 Field extraction SHALL be per opcode:
- 0110011 / 0111011: R; rd, rs1, rs2, funct3, funct7.
- 0010011 / 0000011 / 1100111: I.
- 0011011: I, plus funct7.
- 0100011: S.
- 1100011: B.
- 0110111 / 0010111: U.
- 1101111: J.
- Fields unused by a format SHALL be 0.
REQ-005 Immediates SHALL be sign-extended from instr[31] to XLEN; B and J immediates SHALL have bit 0 = 0; the U immediate SHALL be instr[31:12] followed by 12 zero bits.
REQ-006 When XLEN=32, opcodes 0011011 and 0111011 SHALL decode as format 7.
REQ-007 Unknown opcodes, or instr[1:0] != 2'b11, SHALL produce format 7 with all other fields 0.
REQ-008 in_ready SHALL equal !full; there is no full-queue bypass, so a simultaneous pop does not enable a push while full.
REQ-009 out_valid SHALL equal !empty; the head SHALL pop when out_valid && out_ready.
REQ-010 A simultaneous push and pop when neither full nor empty SHALL keep the count unchanged.
REQ-011 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL be $clog2(DEPTH)+1 bits.
REQ-012 flush SHALL empty the queue at the next edge; an accept in the flush cycle SHALL be discarded; in_ready SHALL remain !full during flush.
REQ-013 The out_* fields SHALL be 0 whenever out_valid=0.

Reset
REQ-014 While rst=1: pointers, count, out_valid and out_illegal = 0; in_ready = 1; all out_* data = 0.
REQ-015 rst asserted mid-operation SHALL drop all queued entries immediately, regardless of handshakes in flight.

Configuration
REQ-016 With DECODE_ILLEGAL_CHECK_EN defined:
- out_illegal = 1 for format-7 entries.
- out_illegal = 1 for R-type with funct7 not in {0000000, 0100000}.
REQ-017 Without DECODE_ILLEGAL_CHECK_EN: out_illegal SHALL be tied 0, and the funct7 check SHALL be absent (format still 7 for unknown opcodes).

Structure
REQ-018 Package decode_pkg SHALL hold:
- the opcode localparams;
- the format enum (3 bits);
- the packed struct decoded_t (pc, rd, rs1, rs2, funct3, funct7, imm, format, illegal), parametrised via XLEN_MAX=64, truncated at use.
REQ-019 Field extraction SHALL be the combinational sub-module decode_comb; the queue and handshake logic SHALL live in decode_stage.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- XLEN=64, 0xFFF10093 (addi x1,x2,-1) -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFF, format=1.
- 0xFE208EE3 (beq x1,x2,-4) -> format=3, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFFFFFFFFFC; 0x123452B7 (lui x5) -> rd=5, imm=0x0000000012345000, format=4.
- DEPTH=2, out_ready=0, 3 back-to-back pushes -> in_ready=0 after the second accept, third held; a pop frees one slot, and in_ready=1 the next cycle.
- Queue holds 2 entries; flush=1 with in_valid=1 in the same cycle -> out_valid=0 next cycle, count=0, pushed entry lost.
- 0x00000000 with DECODE_ILLEGAL_CHECK_EN -> format=7, out_illegal=1; without the macro -> out_illegal=0. XLEN=32 with 0x0000009B -> format=7.
- rst pulsed asynchronously between clock edges with 1 entry queued -> out_valid=0 at once, in_ready=1, all outputs 0.
